alu_ex_stage: RTL and testbench
===============================

Name: alu_ex_stage

Overview:
- Registered execute stage of the cpu32 integer ALU.
- Accepts a decoded operation from issue, computes the result, and holds it in a single output register for writeback.
- Uses valid/ready handshakes on both sides.
- Implements the full integer op set. SLT/SLTU follow the signed/unsigned less-than rule: result in bit 0, bits 31:1 zero.

Parameters:
- XLEN, 32, operand and result width. Only 32 is supported.
- RD_W, 5, destination register index width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  discard the held result and any input offered this cycle
- in_valid  input  1  issue presents an operation
- in_ready  output  1  stage can accept this cycle
- in_op  input  4  operation code (see Behaviour)
- in_a  input  XLEN  operand A
- in_b  input  XLEN  operand B; bits 4:0 are the shift amount for shifts
- in_rd  input  RD_W  destination register tag
- out_valid  output  1  result register holds a valid entry
- out_ready  input  1  writeback consumes this cycle
- out_result  output  XLEN  registered result
- out_rd  output  RD_W  registered destination tag
- out_zero  output  1  registered (result == 0)
- out_illegal  output  1  registered; op code was not defined

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_result=0, out_rd=0, out_zero=0, out_illegal=0, effective immediately.
- in_ready = !flush && (!out_valid || out_ready). This is combinational: a full register that drains this cycle can accept a new entry.
- Accept when in_valid && in_ready. On the next edge the output register loads the result, in_rd, zero and illegal flags, and out_valid=1.
- Latency: 1 cycle from accept to out_valid. Sustained throughput is 1 op/cycle while out_ready=1.
- Drain without new accept (out_valid && out_ready && !accept): out_valid=0 next edge. Data fields may hold their stale values.
- Stall (out_valid && !out_ready): all out_* hold stable. in_ready=0.
- Flush: next edge out_valid=0, no accept occurs, and the held entry is dropped even if out_ready=1. Flush takes priority over in_valid and out_ready in the same cycle.
- in_op encoding (32-bit wrap, no overflow detection):
  - 0 ADD: a+b
  - 1 SUB: a-b
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SLL: a << b[4:0]
  - 6 SRL: logical right shift by b[4:0]
  - 7 SRA: arithmetic right shift by b[4:0]
  - 8 SLT: {31'b0, signed(a)<signed(b)}
  - 9 SLTU: {31'b0, a<b}
  - 10–15: result 0, out_illegal=1
- Shift amount uses only b[4:0]; bits 31:5 are ignored.
- out_zero is computed from the registered result, including for illegal ops (illegal ops give out_zero=1).
- Inputs are sampled only on accept. Values of in_* while in_valid=0 or in_ready=0 have no effect.
- Reset asserted mid-stall clears the entry. After release, in_ready=1 when flush=0.

Test Plan:
- Back-to-back, out_ready=1: ADD 0xFFFFFFFF+1 (rd=3), then SUB 0-1 (rd=4) on consecutive cycles → results 0x00000000 with zero=1 and rd=3, then 0xFFFFFFFF with rd=4, one cycle after each accept; in_ready stays 1.
- Compare ops: SLT a=0x80000000, b=1 → 0x00000001. SLTU same operands → 0x00000000 with zero=1. SLT a=5, b=5 → 0.
- Shifts: SRA a=0x80000000, b=0x00000024 (amount 4) → 0xF8000000. SRL same operands → 0x08000000. SLL a=1, b=31 → 0x80000000.
- Backpressure: out_ready=0 with an entry held → in_ready=0 and out_result stable for 5 cycles. Raise out_ready with a new op offered → drain and accept in the same cycle; the new result appears next cycle.
- Flush: entry held (out_ready=0) and in_valid=1 with flush=1 → next cycle out_valid=0, the offered op is not accepted, and in_ready was 0 during the flush cycle.
- Illegal op and reset: op=12 → out_illegal=1, result 0, zero=1. Then assert rst_n=0 mid-stall → out_valid drops without waiting for a clock edge, and all outputs are 0.

Source files
------------

// File: rtl/alu_ex_stage.sv
// Registered execute stage of the cpu32 integer ALU.
// Issues one op per cycle into a single output register with valid/ready on both sides.
`timescale 1ns/1ps

module alu_ex_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [RD_W-1:0] in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [RD_W-1:0] out_rd,
  output logic            out_zero,
  output logic            out_illegal
);

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_result_q, out_result_d;
  logic [RD_W-1:0] out_rd_q, out_rd_d;
  logic            out_zero_q, out_zero_d;
  logic            out_illegal_q, out_illegal_d;

  logic            accept;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_res;
  logic            alu_illegal;

  // A full register that drains this cycle can take a new entry at once.
  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign shamt    = in_b[4:0];

  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    case (in_op)
      4'd0:    alu_res = in_a + in_b;
      4'd1:    alu_res = in_a - in_b;
      4'd2:    alu_res = in_a & in_b;
      4'd3:    alu_res = in_a | in_b;
      4'd4:    alu_res = in_a ^ in_b;
      4'd5:    alu_res = in_a << shamt;
      4'd6:    alu_res = in_a >> shamt;
      4'd7:    alu_res = $unsigned($signed(in_a) >>> shamt);
      4'd8:    alu_res = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      4'd9:    alu_res = {{(XLEN-1){1'b0}}, (in_a < in_b)};
      default: alu_illegal = 1'b1;
    endcase
  end

  // Flush wins over both a new accept and a drain.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_rd_d      = out_rd_q;
    out_zero_d    = out_zero_q;
    out_illegal_d = out_illegal_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d   = 1'b1;
      out_result_d  = alu_res;
      out_rd_d      = in_rd;
      out_zero_d    = (alu_res == '0);
      out_illegal_d = alu_illegal;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_rd_q      <= '0;
      out_zero_q    <= 1'b0;
      out_illegal_q <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_rd_q      <= out_rd_d;
      out_zero_q    <= out_zero_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_rd      = out_rd_q;
  assign out_zero    = out_zero_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Self-checking bench for alu_ex_stage: directed steps then randomized traffic
// against a transaction-level reference model.
`timescale 1ns/1ps

module tb_alu_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_zero;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  // Reference model: the entry the output register should be holding.
  logic        m_valid;
  logic [31:0] m_result;
  logic [4:0]  m_rd;
  logic        m_zero;
  logic        m_illegal;

  alu_ex_stage #(.XLEN(32), .RD_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_rd       (in_rd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_rd      (out_rd),
    .out_zero    (out_zero),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r,
                                  output logic ill);
    longint sa;
    longint sb;
    longint unsigned ua;
    longint unsigned ub;
    int sh;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    sh  = int'(b[4:0]);
    ill = 1'b0;
    r   = 32'h0;
    case (op)
      4'd0:    r = 32'(ua + ub);
      4'd1:    r = 32'(ua - ub);
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = 32'(ua * (64'd1 << sh));
      4'd6:    r = 32'(ua / (64'd1 << sh));
      4'd7:    r = 32'(sa >>> sh);
      4'd8:    r = (sa < sb) ? 32'd1 : 32'd0;
      4'd9:    r = (ua < ub) ? 32'd1 : 32'd0;
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkVal("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    if (m_valid) begin
      checkVal("out_result", out_result, m_result);
      checkVal("out_rd", {27'b0, out_rd}, {27'b0, m_rd});
      checkVal("out_zero", {31'b0, out_zero}, {31'b0, m_zero});
      checkVal("out_illegal", {31'b0, out_illegal}, {31'b0, m_illegal});
    end
  endtask

  // One cycle: drive after the falling edge, check ready, advance the model
  // across the rising edge, then check the register on the next falling edge.
  task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd,
                               input logic fl, input logic ordy);
    logic        exp_ready;
    logic [31:0] r;
    logic        ill;
    in_valid  = v;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    in_rd     = rd;
    flush     = fl;
    out_ready = ordy;
    #1;
    exp_ready = !fl && (!m_valid || ordy);
    checkVal("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
    @(posedge clk);
    if (fl) begin
      m_valid = 1'b0;
    end else if (v && exp_ready) begin
      ref_alu(op, a, b, r, ill);
      m_valid   = 1'b1;
      m_result  = r;
      m_rd      = rd;
      m_zero    = (r == 32'h0);
      m_illegal = ill;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    checkOutput();
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, "_valid"}, {31'b0, out_valid}, 32'h0);
    checkVal({tag, "_result"}, out_result, 32'h0);
    checkVal({tag, "_rd"}, {27'b0, out_rd}, 32'h0);
    checkVal({tag, "_zero"}, {31'b0, out_zero}, 32'h0);
    checkVal({tag, "_illegal"}, {31'b0, out_illegal}, 32'h0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] held;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 4'd0;
    in_a = 32'h0; in_b = 32'h0; in_rd = 5'd0; out_ready = 1'b0;
    m_valid = 1'b0; m_result = 32'h0; m_rd = 5'd0; m_zero = 1'b0; m_illegal = 1'b0;

    @(negedge clk);
    @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back wraparound ADD then SUB.
    applyStimulus(1, 4'd0, 32'hFFFF_FFFF, 32'h1, 5'd3, 0, 1);
    checkVal("b2b_add", out_result, 32'h0);
    applyStimulus(1, 4'd1, 32'h0, 32'h1, 5'd4, 0, 1);
    checkVal("b2b_sub", out_result, 32'hFFFF_FFFF);

    // Compare ops.
    applyStimulus(1, 4'd8, 32'h8000_0000, 32'h1, 5'd5, 0, 1);
    checkVal("slt_neg", out_result, 32'h1);
    applyStimulus(1, 4'd9, 32'h8000_0000, 32'h1, 5'd6, 0, 1);
    checkVal("sltu_big", out_result, 32'h0);
    applyStimulus(1, 4'd8, 32'd5, 32'd5, 5'd7, 0, 1);
    checkVal("slt_eq", out_result, 32'h0);

    // Shifts with an oversized amount field.
    applyStimulus(1, 4'd7, 32'h8000_0000, 32'h24, 5'd8, 0, 1);
    checkVal("sra", out_result, 32'hF800_0000);
    applyStimulus(1, 4'd6, 32'h8000_0000, 32'h24, 5'd9, 0, 1);
    checkVal("srl", out_result, 32'h0800_0000);
    applyStimulus(1, 4'd5, 32'h1, 32'd31, 5'd10, 0, 1);
    checkVal("sll", out_result, 32'h8000_0000);

    // Backpressure: hold for 5 cycles, then drain and accept together.
    applyStimulus(1, 4'd3, 32'h1234_0000, 32'h0000_5678, 5'd11, 0, 0);
    held = out_result;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 4'd2, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 5'd12, 0, 0);
      checkVal("stall_stable", out_result, held);
    end
    applyStimulus(1, 4'd4, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd13, 0, 1);
    checkVal("drain_accept", out_result, 32'hF00F_F00F);

    // Flush while holding and offering a new op.
    applyStimulus(1, 4'd0, 32'd7, 32'd8, 5'd14, 0, 0);
    applyStimulus(1, 4'd0, 32'd1, 32'd1, 5'd15, 1, 0);
    checkVal("flush_drop", {31'b0, out_valid}, 32'h0);

    // Illegal op held, then asynchronous reset mid-stall.
    applyStimulus(1, 4'd12, 32'hDEAD_BEEF, 32'h1, 5'd16, 0, 0);
    checkVal("illegal_flag", {31'b0, out_illegal}, 32'h1);
    applyStimulus(0, 4'd0, 32'h0, 32'h0, 5'd0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_reset");
    m_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkVal("ready_after_reset", {31'b0, in_ready}, 32'h1);
    @(negedge clk);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      ra = $urandom();
      rb = $urandom();
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) rb = ra;
      applyStimulus($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), ra, rb,
                    5'($urandom_range(0, 31)), $urandom_range(0, 15) == 0,
                    $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
